wave_gen: RTL

Single-voice waveform generator between the MCU command receiver and the DAC transmitter. It decodes 16-bit command words delivered by `spiMcu` and runs a 16-bit phase accumulator at a fixed sample rate. Each sample period it produces one 8-bit square, saw or triangle sample. It hands each sample to `spiDac` as `voltageVal` with a one-cycle `start` pulse.

---
 rtl/wave_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - single-voice square/saw/triangle generator feeding spiDac
// Optional amplitude scaling is built when WAVE_GEN_AMP_EN is defined.
module wave_gen #(
  parameter int SAMPLE_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mcu_word,
  input  logic        mcu_done,
  output logic [7:0]  dac_data,
  output logic        dac_start,
  output logic        cmd_strobe
);
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  logic        done_s1, done_s2, done_d;
  logic [15:0] cmd_reg;
  logic [3:0]  opcode;
  logic [11:0] data;
  logic [11:0] inc;
  logic [1:0]  wave;
  logic [15:0] phase;
  logic [15:0] div_cnt;
  logic        tick, s1_go, s2_go;
  logic [7:0]  p, raw_sample, sample;

  assign opcode = cmd_reg[15:12];
  assign data   = cmd_reg[11:0];
  assign tick   = (div_cnt == DIV_LAST);
  assign p      = phase[15:8];

  // Flops reset high so the idle link never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1    <= 1'b1;
      done_s2    <= 1'b1;
      done_d     <= 1'b1;
      cmd_reg    <= 16'h0000;
      cmd_strobe <= 1'b0;
    end else begin
      done_s1    <= mcu_done;
      done_s2    <= done_s1;
      done_d     <= done_s2;
      cmd_strobe <= done_s2 & ~done_d;
      if (done_s2 & ~done_d)
        cmd_reg <= mcu_word;
    end
  end

  always_comb begin
    raw_sample = 8'h80;
    case (wave)
      2'd0: raw_sample = p[7] ? 8'hFF : 8'h00;
      2'd1: raw_sample = p;
      2'd2: raw_sample = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: raw_sample = 8'h80;
    endcase
  end

`ifdef WAVE_GEN_AMP_EN
  logic [7:0] amp;
  logic [7:0] scaled;

  assign scaled = 8'((17'(raw_sample) * (17'(amp) + 17'd1)) >> 8);
  assign sample = (wave == 2'd3) ? 8'h80 : scaled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      amp <= 8'hFF;
    else if (cmd_strobe && opcode == 4'h3)
      amp <= data[7:0];
  end
`else
  assign sample = raw_sample;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc       <= 12'h000;
      wave      <= 2'd3;
      phase     <= 16'h0000;
      div_cnt   <= 16'h0000;
      s1_go     <= 1'b0;
      s2_go     <= 1'b0;
      dac_data  <= 8'h80;
      dac_start <= 1'b0;
    end else begin
      div_cnt <= tick ? 16'h0000 : div_cnt + 16'h0001;
      s1_go   <= tick;
      s2_go   <= s1_go;

      if (cmd_strobe && opcode == 4'h1)
        inc <= data;
      if (cmd_strobe && opcode == 4'h2)
        wave <= data[1:0];

      // A phase reset landing on the stage-1 edge wins and drops that increment.
      if (cmd_strobe && opcode == 4'h4)
        phase <= 16'h0000;
      else if (s1_go)
        phase <= phase + {4'h0, inc};

      dac_start <= s2_go;
      if (s2_go)
        dac_data <= sample;
    end
  end

endmodule
